// File: rtl/aes_key_schedule.sv
// Word-serial AES key expansion for 128/192/256-bit keys: one 32-bit word per
// cycle into a word store, with round keys read back by index combinationally.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] xx;
      p  = 8'h00;
      xx = x;
      for (int b = 0; b < 8; b++) begin
         if (y[b]) p = p ^ xx;
         xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 by an addition chain (0 maps to 0).
   logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, inv;
   assign a2   = gmul(a, a);
   assign a3   = gmul(a2, a);
   assign a6   = gmul(a3, a3);
   assign a12  = gmul(a6, a6);
   assign a15  = gmul(a12, a3);
   assign a30  = gmul(a15, a15);
   assign a60  = gmul(a30, a30);
   assign a120 = gmul(a60, a60);
   assign a240 = gmul(a120, a120);
   assign inv  = gmul(gmul(a240, a12), a2);

   assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_key_schedule #(
   parameter int MAX_KEY_BITS = 256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic [255:0] key_in,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic         keys_ready,
   output logic [3:0]   nr,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_out
);
   localparam int DEPTH = 4 * (MAX_KEY_BITS / 32 + 7);

   typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

   state_t       state_reg;
   logic [255:0] key_reg;
   logic [3:0]   nk_reg, nr_reg;
   logic [5:0]   i_reg, last_reg;
   logic [2:0]   imod_reg;
   logic [7:0]   rcon_reg;
   logic         busy_reg, done_reg, err_reg, keys_ready_reg;

   logic [31:0]  w_mem [DEPTH];

   logic [3:0]   nk_dec, nr_dec;
   logic [5:0]   last_dec;
   logic         mode_ok;

   always_comb begin
      nk_dec = 4'd0;
      nr_dec = 4'd0;
      case (mode)
         2'd1:    begin nk_dec = 4'd4; nr_dec = 4'd10; end
         2'd2:    begin nk_dec = 4'd6; nr_dec = 4'd12; end
         2'd3:    begin nk_dec = 4'd8; nr_dec = 4'd14; end
         default: begin nk_dec = 4'd0; nr_dec = 4'd0; end
      endcase
      mode_ok  = (mode != 2'd0) && (32 * int'(nk_dec) <= MAX_KEY_BITS);
      last_dec = {nr_dec + 4'd1, 2'b00} - 6'd1;
   end

   // Expansion datapath: temp from w[i-1], combined with w[i-Nk].
   logic [31:0] w_prev, w_back, rot, sub_in, sub_out, temp, w_new;
   assign w_prev = w_mem[i_reg - 6'd1];
   assign w_back = w_mem[i_reg - {2'b00, nk_reg}];
   assign rot    = {w_prev[23:0], w_prev[31:24]};
   assign sub_in = (imod_reg == 3'd0) ? rot : w_prev;

   for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (.a(sub_in[8*gi +: 8]), .s(sub_out[8*gi +: 8]));
   end

   always_comb begin
      temp = w_prev;
      if (imod_reg == 3'd0)
         temp = sub_out ^ {rcon_reg, 24'h000000};
      else if (nk_reg == 4'd8 && imod_reg == 3'd4)
         temp = sub_out;
      w_new = w_back ^ temp;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         key_reg        <= '0;
         nk_reg         <= 4'd0;
         nr_reg         <= 4'd0;
         i_reg          <= 6'd0;
         last_reg       <= 6'd0;
         imod_reg       <= 3'd0;
         rcon_reg       <= 8'h00;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
         keys_ready_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (mode_ok) begin
                     key_reg        <= key_in;
                     nk_reg         <= nk_dec;
                     nr_reg         <= nr_dec;
                     last_reg       <= last_dec;
                     keys_ready_reg <= 1'b0;
                     busy_reg       <= 1'b1;
                     state_reg      <= LOAD;
                  end else begin
                     err_reg <= 1'b1;
                  end
               end
            end
            LOAD: begin
               i_reg     <= {2'b00, nk_reg};
               imod_reg  <= 3'd0;
               rcon_reg  <= 8'h01;
               state_reg <= EXPAND;
            end
            EXPAND: begin
               i_reg    <= i_reg + 6'd1;
               imod_reg <= ({1'b0, imod_reg} == nk_reg - 4'd1) ? 3'd0 : imod_reg + 3'd1;
               if (imod_reg == 3'd0)
                  rcon_reg <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
               if (i_reg == last_reg)
                  state_reg <= DONE;
            end
            DONE: begin
               done_reg       <= 1'b1;
               busy_reg       <= 1'b0;
               keys_ready_reg <= 1'b1;
               state_reg      <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Word store has no reset; stale contents stay hidden behind keys_ready.
   always_ff @(posedge clk) begin
      if (state_reg == LOAD) begin
         for (int j = 0; j < 8; j++)
            if (j < int'(nk_reg))
               w_mem[6'(j)] <= key_reg[255 - 32*j -: 32];
      end else if (state_reg == EXPAND) begin
         w_mem[i_reg] <= w_new;
      end
   end

   logic [5:0]  rk_base;
   logic [31:0] rk_word [4];
   logic        rk_valid;
   assign rk_base  = {rk_idx, 2'b00};
   assign rk_valid = keys_ready_reg && (rk_idx <= nr_reg);

   for (genvar gi = 0; gi < 4; gi++) begin : g_rk
      assign rk_word[gi] = w_mem[rk_base + 6'(gi)];
   end

   assign rk_out     = rk_valid ? {rk_word[0], rk_word[1], rk_word[2], rk_word[3]} : 128'h0;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign err        = err_reg;
   assign keys_ready = keys_ready_reg;
   assign nr         = keys_ready_reg ? nr_reg : 4'd0;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: FIPS-197 key expansions, latency, error and reset cases.

module tb_aes_key_schedule;
   typedef struct { logic [1:0] mode; logic [255:0] key; int lat; logic [3:0] nr; } ex_t;
   typedef struct { int run; logic [3:0] idx; logic [127:0] rk; } rk_t;
   typedef struct { int lat; logic [3:0] nr; } sb_t;

   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                      128'hdeadbeefcafef00d0123456789abcdef};
   localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                      64'h5a5a5a5aa5a5a5a5};
   localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic         clk, rst, start, busy, done, err, keys_ready;
   logic [1:0]   mode;
   logic [255:0] key_in;
   logic [3:0]   nr, rk_idx;
   logic [127:0] rk_out;

   logic         s_start, s_busy, s_done, s_err, s_kr;
   logic [1:0]   s_mode;
   logic [255:0] s_key;
   logic [3:0]   s_nr, s_idx;
   logic [127:0] s_rk;

   aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in),
      .busy(busy), .done(done), .err(err), .keys_ready(keys_ready), .nr(nr),
      .rk_idx(rk_idx), .rk_out(rk_out)
   );

   aes_key_schedule #(.MAX_KEY_BITS(128)) dut128 (
      .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .key_in(s_key),
      .busy(s_busy), .done(s_done), .err(s_err), .keys_ready(s_kr), .nr(s_nr),
      .rk_idx(s_idx), .rk_out(s_rk)
   );

   ex_t  ex_tab [3];
   rk_t  rk_tab [16];
   sb_t  exp_q [$];
   int   n_vec = 0;
   int   n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one start, optionally pulses extra starts while busy, and scores done.
   task automatic expand(input logic [1:0] m, input logic [255:0] k, input int lat,
                         input logic [3:0] n, input bit spam);
      sb_t e;
      int  cyc;
      bit  seen_err;
      e.lat = lat;
      e.nr  = n;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b1; mode = m; key_in = k;
      cyc = 0; seen_err = 1'b0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check("busy_after_start", busy, 1);
         if (err) seen_err = 1'b1;
         if (spam && cyc >= 2 && cyc <= 12 && cyc % 2 == 0) begin
            start = 1'b1; mode = 2'd2; key_in = KEY192;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      e = exp_q.pop_front();
      if (!done) begin
         n_vec++; n_bad++;
         $display("FAIL done_timeout: no done after %0d cycles, expected %0d", cyc, e.lat);
      end else begin
         check("latency", 256'(cyc - 1), 256'(e.lat));
         check("nr_after_done", nr, e.nr);
         check("keys_ready_after_done", keys_ready, 1);
         check("busy_at_done", busy, 0);
      end
      check("no_err_during_run", seen_err, 0);
      $display("expand mode=%0d latency=%0d nr=%0d", m, cyc - 1, nr);
   endtask

   task automatic readback(input int run);
      for (int r = 0; r < 16; r++) begin
         if (rk_tab[r].run == run) begin
            rk_idx = rk_tab[r].idx;
            #1;
            check($sformatf("rk_run%0d_idx%0d", run, rk_tab[r].idx), rk_out, rk_tab[r].rk);
            $display("read run=%0d idx=%0d rk=%h", run, rk_tab[r].idx, rk_out);
         end
      end
   endtask

   initial begin
      int cyc;
      ex_tab[0] = '{mode: 2'd1, key: KEY128, lat: 42, nr: 4'd10};
      ex_tab[1] = '{mode: 2'd2, key: KEY192, lat: 48, nr: 4'd12};
      ex_tab[2] = '{mode: 2'd3, key: KEY256, lat: 54, nr: 4'd14};

      rk_tab[0]  = '{run: 0, idx: 4'd0,  rk: 128'h2b7e151628aed2a6abf7158809cf4f3c};
      rk_tab[1]  = '{run: 0, idx: 4'd1,  rk: 128'ha0fafe1788542cb123a339392a6c7605};
      rk_tab[2]  = '{run: 0, idx: 4'd2,  rk: 128'hf2c295f27a96b9435935807a7359f67f};
      rk_tab[3]  = '{run: 0, idx: 4'd9,  rk: 128'hac7766f319fadc2128d12941575c006e};
      rk_tab[4]  = '{run: 0, idx: 4'd10, rk: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      rk_tab[5]  = '{run: 0, idx: 4'd11, rk: 128'h0};
      rk_tab[6]  = '{run: 0, idx: 4'd15, rk: 128'h0};
      rk_tab[7]  = '{run: 1, idx: 4'd0,  rk: 128'h8e73b0f7da0e6452c810f32b809079e5};
      rk_tab[8]  = '{run: 1, idx: 4'd1,  rk: 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
      rk_tab[9]  = '{run: 1, idx: 4'd12, rk: 128'he98ba06f448c773c8ecc720401002202};
      rk_tab[10] = '{run: 1, idx: 4'd13, rk: 128'h0};
      rk_tab[11] = '{run: 2, idx: 4'd0,  rk: 128'h603deb1015ca71be2b73aef0857d7781};
      rk_tab[12] = '{run: 2, idx: 4'd1,  rk: 128'h1f352c073b6108d72d9810a30914dff4};
      rk_tab[13] = '{run: 2, idx: 4'd2,  rk: 128'h9ba354118e6925afa51a8b5f2067fcde};
      rk_tab[14] = '{run: 2, idx: 4'd14, rk: 128'hfe4890d1e6188d0b046df344706c631e};
      rk_tab[15] = '{run: 2, idx: 4'd15, rk: 128'h0};

      rst = 1'b1; start = 1'b0; mode = 2'd0; key_in = '0; rk_idx = 4'd0;
      s_start = 1'b0; s_mode = 2'd0; s_key = '0; s_idx = 4'd0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_err", err, 0);
      check("reset_keys_ready", keys_ready, 0);
      check("reset_nr", nr, 0);
      check("reset_rk_out", rk_out, 0);
      rst = 1'b0;

      for (int r = 0; r < 3; r++) begin
         expand(ex_tab[r].mode, ex_tab[r].key, ex_tab[r].lat, ex_tab[r].nr, 1'b0);
         readback(r);
      end

      // Illegal mode: err pulse, stored 256-bit schedule untouched.
      @(negedge clk);
      start = 1'b1; mode = 2'd0; key_in = KEY128;
      @(negedge clk);
      start = 1'b0;
      check("mode0_err", err, 1);
      check("mode0_busy", busy, 0);
      check("mode0_done", done, 0);
      check("mode0_keys_ready", keys_ready, 1);
      rk_idx = 4'd14; #1;
      check("mode0_rk_kept", rk_out, 128'hfe4890d1e6188d0b046df344706c631e);
      @(negedge clk);
      check("mode0_err_one_cycle", err, 0);
      $display("illegal mode start: err pulse checked");

      // Reset sampled at edge E0+20 of a mode-1 run.
      @(negedge clk);
      start = 1'b1; mode = 2'd1; key_in = KEY128;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rk_idx = 4'd0; #1;
      check("midrun_reset_busy", busy, 0);
      check("midrun_reset_keys_ready", keys_ready, 0);
      check("midrun_reset_nr", nr, 0);
      check("midrun_reset_rk_out", rk_out, 0);
      $display("reset mid-expansion checked");
      expand(2'd1, KEY128, 42, 4'd10, 1'b0);
      readback(0);

      // Starts while busy are ignored; back-to-back start right after done.
      expand(2'd1, KEY128, 42, 4'd10, 1'b1);
      readback(0);
      expand(2'd3, KEY256, 54, 4'd14, 1'b0);
      readback(2);

      // Instance limited to 128-bit keys.
      @(negedge clk);
      s_start = 1'b1; s_mode = 2'd3; s_key = KEY256;
      @(negedge clk);
      s_start = 1'b0;
      check("max128_mode3_err", s_err, 1);
      check("max128_mode3_busy", s_busy, 0);
      s_start = 1'b1; s_mode = 2'd2; s_key = KEY192;
      @(negedge clk);
      s_start = 1'b0;
      check("max128_mode2_err", s_err, 1);
      s_start = 1'b1; s_mode = 2'd1; s_key = KEY128;
      cyc = 0;
      while (!s_done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         s_start = 1'b0;
      end
      if (!s_done) begin
         n_vec++; n_bad++;
         $display("FAIL max128_timeout: no done after %0d cycles, expected 42", cyc);
      end else begin
         check("max128_latency", 256'(cyc - 1), 256'd42);
      end
      s_idx = 4'd10; #1;
      check("max128_rk10", s_rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("max128_nr", s_nr, 4'd10);
      $display("max128 instance mode=1 latency=%0d rk10=%h", cyc - 1, s_rk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
